// File: rtl/zmod_pll_sequencer_if.sv
// Control/status bundle between the PLL sequencer and its control path.
// The slave side is the sequencer itself.
interface zmod_pll_sequencer_if;
  logic       enable;
  logic       pll_locked;
  logic       relock_req;
  logic       pll_rst;
  logic       pll_pwrdwn;
  logic       out_rst;
  logic       ready;
  logic       lock_fail;
  logic [7:0] loss_count;
  logic [2:0] state;

  modport master (
    output enable, pll_locked, relock_req,
    input  pll_rst, pll_pwrdwn, out_rst,
    input  ready, lock_fail, loss_count, state
  );

  modport slave (
    input  enable, pll_locked, relock_req,
    output pll_rst, pll_pwrdwn, out_rst,
    output ready, lock_fail, loss_count, state
  );
endinterface

// File: rtl/zmod_pll_sequencer.sv
// Reset/lock sequencer for the ZMOD transmit PLL: reset pulse, lock
// qualification, retry, relock and lock-loss reporting.
module zmod_pll_sequencer #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 100000,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 4
) (
  input logic                  clk,
  input logic                  rst,
  zmod_pll_sequencer_if.slave  bus
);

  localparam int RW = $clog2(RST_CYCLES) + 1;
  localparam int TW = $clog2(LOCK_TIMEOUT) + 1;
  localparam int SW = $clog2(STABLE_CYCLES) + 1;
  localparam int AW = $clog2(MAX_RETRIES) + 1;

  localparam logic [RW-1:0] R_LAST = RW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] T_LAST = TW'(LOCK_TIMEOUT - 1);
  localparam logic [SW-1:0] S_LAST = SW'(STABLE_CYCLES - 1);
  localparam logic [AW-1:0] A_MAX  = AW'(MAX_RETRIES);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RESET     = 3'd1,
    WAIT_LOCK = 3'd2,
    STABLE    = 3'd3,
    RUN       = 3'd4,
    FAIL      = 3'd5
  } state_t;

  state_t        st;
  logic          s1;
  logic          lk;
  logic [RW-1:0] rcnt;
  logic [TW-1:0] tcnt;
  logic [SW-1:0] scnt;
  logic [AW-1:0] att;
  logic [AW-1:0] att_inc;
  logic [7:0]    lcnt;
  logic          pll_rst_q;
  logic          pwrdwn_q;
  logic          out_rst_q;
  logic          ready_q;
  logic          fail_q;

  assign att_inc = att + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= IDLE;
      s1        <= 1'b0;
      lk        <= 1'b0;
      rcnt      <= '0;
      tcnt      <= '0;
      scnt      <= '0;
      att       <= '0;
      lcnt      <= '0;
      pll_rst_q <= 1'b1;
      pwrdwn_q  <= 1'b1;
      out_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      s1 <= bus.pll_locked;
      lk <= s1;
      if (!bus.enable) begin
        st        <= IDLE;
        att       <= '0;
        pll_rst_q <= 1'b1;
        pwrdwn_q  <= 1'b1;
        out_rst_q <= 1'b1;
        ready_q   <= 1'b0;
        fail_q    <= 1'b0;
      end else begin
        unique case (st)
          IDLE: begin
            st       <= RESET;
            rcnt     <= '0;
            pwrdwn_q <= 1'b0;
          end
          RESET: begin
            if (rcnt == R_LAST) begin
              st        <= WAIT_LOCK;
              tcnt      <= '0;
              pll_rst_q <= 1'b0;
            end else begin
              rcnt <= rcnt + 1'b1;
            end
          end
          WAIT_LOCK: begin
            if (lk) begin
              st   <= STABLE;
              scnt <= '0;
            end else if (tcnt == T_LAST) begin
              att       <= att_inc;
              pll_rst_q <= 1'b1;
              if (att_inc == A_MAX) begin
                st     <= FAIL;
                fail_q <= 1'b1;
              end else begin
                st   <= RESET;
                rcnt <= '0;
              end
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
          STABLE: begin
            if (!lk) begin
              st   <= WAIT_LOCK;
              tcnt <= '0;
            end else if (scnt == S_LAST) begin
              st        <= RUN;
              att       <= '0;
              ready_q   <= 1'b1;
              out_rst_q <= 1'b0;
            end else begin
              scnt <= scnt + 1'b1;
            end
          end
          RUN: begin
            // a loss coinciding with a relock request counts once
            if (!lk || bus.relock_req) begin
              if (!lk && lcnt != 8'hFF) lcnt <= lcnt + 1'b1;
              st        <= RESET;
              rcnt      <= '0;
              pll_rst_q <= 1'b1;
              ready_q   <= 1'b0;
              out_rst_q <= 1'b1;
            end
          end
          FAIL: begin
          end
          default: st <= IDLE;
        endcase
      end
    end
  end

  assign bus.state      = st;
  assign bus.pll_rst    = pll_rst_q;
  assign bus.pll_pwrdwn = pwrdwn_q;
  assign bus.out_rst    = out_rst_q;
  assign bus.ready      = ready_q;
  assign bus.lock_fail  = fail_q;
  assign bus.loss_count = lcnt;

endmodule

// File: doc/zmod_pll_sequencer.md
# zmod_pll_sequencer

Reset and lock sequencer for the ZMOD transmit PLL. The block runs on the free-running PLL reference clock and drives the PLL reset and power-down pins. It waits for a qualified lock, then releases a reset for the logic in the `clkout`/`clkoutx4` domains. It retries failed lock attempts, restarts the PLL when lock is lost, and reports lock losses and lock failure to the control path.

## Interface
- `RST_CYCLES`, 16: cycles `pll_rst` is held high per attempt (≥1).
- `LOCK_TIMEOUT`, 100000: cycles allowed in WAIT_LOCK before the attempt is declared failed (1 ms at 100 MHz).
- `STABLE_CYCLES`, 1024: consecutive synchronized-locked cycles required before `ready`.
- `MAX_RETRIES`, 4: failed attempts allowed before FAIL (≥1).

- `clk`  in  1  PLL reference clock, free-running.
- `rst`  in  1  synchronous, active-high reset.
- `enable`  in  1  level; 0 powers the PLL down.
- `pll_locked`  in  1  PLL LOCKED, asynchronous to `clk`.
- `relock_req`  in  1  single-cycle pulse; forces a PLL restart from RUN.
- `pll_rst`  out  1  to PLL RST.
- `pll_pwrdwn`  out  1  to PLL PWRDWN.
- `out_rst`  out  1  reset for generated-clock logic; high unless `ready`.
- `ready`  out  1  PLL qualified locked.
- `lock_fail`  out  1  retries exhausted.
- `loss_count`  out  8  lock-loss events in RUN, saturating at 255.
- `state`  out  3  encoding: IDLE=0, RESET=1, WAIT_LOCK=2, STABLE=3, RUN=4, FAIL=5.

## Operation
- `pll_locked` passes through a 2-flop synchronizer to give `lk`. All decisions use `lk`.
- Output values by state:
  - IDLE: `pll_pwrdwn`=1, `pll_rst`=1, `out_rst`=1. Go to RESET when `enable`=1.
  - RESET: `pll_pwrdwn`=0, `pll_rst`=1 for exactly RST_CYCLES cycles, then WAIT_LOCK.
  - WAIT_LOCK: `pll_rst`=0. The timer counts from 0.
    - `lk`=1 → STABLE.
    - Timer reaches LOCK_TIMEOUT−1 with `lk`=0 → attempt counter +1. If the count equals MAX_RETRIES, go to FAIL; otherwise go to RESET.
  - STABLE: the stable counter counts while `lk`=1.
    - `lk`=0 → WAIT_LOCK with the timer cleared. The attempt counter is unchanged.
    - Counter reaches STABLE_CYCLES−1 → RUN. The attempt counter clears to 0.
  - RUN: `ready`=1, `out_rst`=0.
    - `lk`=0 → `loss_count`+1 (saturating), then RESET.
    - `relock_req`=1 → RESET. `loss_count` is unchanged.
  - FAIL: `lock_fail`=1, `pll_rst`=1, `pll_pwrdwn`=0, `out_rst`=1. Exit only through `enable`=0 (→ IDLE) or `rst`.
- `enable`=0 in any state → IDLE on the next edge and clears the attempt counter. `lock_fail` clears on IDLE entry. `loss_count` is held.
- `lk`=0 and `relock_req` in the same RUN cycle → RESET, with `loss_count` incremented once.
- `relock_req` outside RUN is ignored.
- Counter widths are $clog2(param)+1. Every counter clears on entry to its state.

## Timing
- `rst`=1 at an edge forces the following values on the next edge, including from mid-sequence:
  - state IDLE;
  - `pll_rst`=1, `pll_pwrdwn`=1, `out_rst`=1;
  - `ready`=0, `lock_fail`=0, `loss_count`=0;
  - all counters and synchronizer flops 0.
- All outputs are registered and change on the edge of the state transition.
- Latencies:
  - `enable` rising edge to `pll_rst` falling edge: RST_CYCLES+1 cycles.
  - `pll_locked` rising edge to `lk`: 2 cycles.
  - `lk` rising edge to `ready`: STABLE_CYCLES+1 cycles.
  - `pll_locked` falling edge in RUN to `ready`/`out_rst` change: 3 cycles. `ready` falls to 0 and `out_rst` rises to 1 on the same edge.
- `ready` and `out_rst` are always complementary.
- `pll_rst` pulse width is exactly RST_CYCLES cycles on every attempt.

## Test plan
- Nominal lock, with RST_CYCLES=4, STABLE_CYCLES=8, model locks 20 cycles after `pll_rst` falls:
  - `enable`=1 → `pll_rst` high 4 cycles;
  - `ready` rises 2+8+1 cycles after `pll_locked` rises;
  - `out_rst` falls on the same edge as `ready` rises.
- No lock, with LOCK_TIMEOUT=50, MAX_RETRIES=3, `pll_locked` held 0:
  - 3 `pll_rst` pulses, then `lock_fail`=1 and `state`=5;
  - `enable`=0 → IDLE with `lock_fail`=0.
- Glitchy lock: `pll_locked` drops for 3 cycles during STABLE → back to WAIT_LOCK, no `ready`, attempt count unchanged, then qualifies normally.
- Loss in RUN: drop `pll_locked` → `ready`=0 3 cycles later, `loss_count`=1, new `pll_rst` pulse, relock to `ready`. Repeat 300 times → `loss_count`=255.
- Relock request:
  - `relock_req` pulse in RUN → RESET with `loss_count` unchanged;
  - pulse in WAIT_LOCK → ignored;
  - pulse coincident with lock loss → `loss_count` incremented by exactly 1.
- Reset mid-operation: assert `rst` in WAIT_LOCK, RUN and FAIL → every output at its reset value on the next edge, `loss_count`=0.
